// File: rtl/rtmc_spi_cmd_if.sv
// Register-bus handshake between the SPI command engine (master) and the register file (slave).
interface rtmc_spi_cmd_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) ();
    logic              reg_req;
    logic              reg_we;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic [DATA_W-1:0] reg_rdata;
    logic              reg_ack;

    modport master (
        output reg_req, reg_we, reg_addr, reg_wdata,
        input  reg_rdata, reg_ack
    );

    modport slave (
        input  reg_req, reg_we, reg_addr, reg_wdata,
        output reg_rdata, reg_ack
    );
endinterface

// File: rtl/rtmc_spi_cmd.sv
// SPI command engine: parses chip-select frames into register read/write requests.
// Optional feature macro RTMC_SPI_WR_ECHO_EN echoes write data after a write acknowledge.

package rtmc_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    typedef enum logic [7:0] {O_NOP = 8'h00, O_RD = 8'h01, O_WR = 8'h02} op_t;
    typedef enum logic [7:0] {R_BUSY = 8'h00, R_ACK = 8'h01, R_ACK_DATA = 8'h02} result_t;
endpackage

module rtmc_spi_cmd
    import rtmc_pkg::*;
#(
    parameter int ADDR_W = rtmc_pkg::ADDR_W,
    parameter int DATA_W = rtmc_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs_n,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic [7:0]            tx_data,
    rtmc_spi_cmd_if.master        bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_WDH, S_WDL, S_WAIT, S_RDATH, S_RDATL, S_DONE, S_IGNORE
    } state_t;

    state_t            state;
    logic              is_wr;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            is_wr         <= 1'b0;
            tx_data       <= 8'h00;
            rdata_q       <= '0;
            bus.reg_req   <= 1'b0;
            bus.reg_we    <= 1'b0;
            bus.reg_addr  <= '0;
            bus.reg_wdata <= '0;
        end else begin
            // The ack always retires the request, even when its frame was aborted.
            if (bus.reg_req && bus.reg_ack)
                bus.reg_req <= 1'b0;

            if (cs_n) begin
                state   <= S_IDLE;
                tx_data <= R_BUSY;
            end else begin
                unique case (state)
                    S_IDLE: if (rx_valid) begin
                        if (bus.reg_req) begin
                            state   <= S_IGNORE;
                            tx_data <= R_BUSY;
                        end else if (rx_data == O_WR || rx_data == O_RD) begin
                            state   <= S_ADDR;
                            is_wr   <= (rx_data == O_WR);
                            tx_data <= R_BUSY;
                        end else if (rx_data == O_NOP) begin
                            state   <= S_DONE;
                            tx_data <= R_ACK;
                        end else begin
                            state   <= S_IGNORE;
                            tx_data <= 8'hFF;
                        end
                    end
                    S_ADDR: if (rx_valid) begin
                        bus.reg_addr <= ADDR_W'(rx_data);
                        if (is_wr) begin
                            state <= S_WDH;
                        end else begin
                            state       <= S_WAIT;
                            bus.reg_req <= 1'b1;
                            bus.reg_we  <= 1'b0;
                        end
                    end
                    S_WDH: if (rx_valid) begin
                        bus.reg_wdata[DATA_W-1 -: 8] <= rx_data;
                        state <= S_WDL;
                    end
                    S_WDL: if (rx_valid) begin
                        bus.reg_wdata[7:0] <= rx_data;
                        bus.reg_req        <= 1'b1;
                        bus.reg_we         <= 1'b1;
                        state              <= S_WAIT;
                    end
                    S_WAIT: begin
                        // Polls while the request is pending only count once the ack has landed.
                        if (bus.reg_req) begin
                            if (bus.reg_ack) begin
                                if (is_wr) begin
                                    tx_data <= R_ACK;
                                    rdata_q <= bus.reg_wdata;
                                end else begin
                                    tx_data <= R_ACK_DATA;
                                    rdata_q <= bus.reg_rdata;
                                end
                            end
                        end else if (rx_valid) begin
`ifdef RTMC_SPI_WR_ECHO_EN
                            state   <= S_RDATH;
                            tx_data <= rdata_q[DATA_W-1 -: 8];
`else
                            if (is_wr) begin
                                state <= S_DONE;
                            end else begin
                                state   <= S_RDATH;
                                tx_data <= rdata_q[DATA_W-1 -: 8];
                            end
`endif
                        end
                    end
                    S_RDATH: if (rx_valid) begin
                        state   <= S_RDATL;
                        tx_data <= rdata_q[7:0];
                    end
                    S_RDATL: if (rx_valid) begin
                        state   <= S_DONE;
                        tx_data <= R_BUSY;
                    end
                    S_DONE, S_IGNORE: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rtmc_spi_cmd.sv
// Self-checking bench for rtmc_spi_cmd: directed frames plus randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_rtmc_spi_cmd;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs_n = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] tx_data;

    rtmc_spi_cmd_if bus_if ();

    rtmc_spi_cmd dut (
        .clk      (clk),
        .rst      (rst),
        .cs_n     (cs_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_data  (tx_data),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Bus responder: acks ack_delay cycles after reg_req rises, optional spurious acks while idle.
    int          ack_delay = 1;
    logic [15:0] rdata_val = 16'h0000;
    bit          noise_en = 1'b0;

    initial begin
        int   cnt;
        logic was;
        cnt = -1;
        bus_if.reg_ack   = 1'b0;
        bus_if.reg_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            was = bus_if.reg_ack;
            bus_if.reg_ack   = 1'b0;
            bus_if.reg_rdata = 16'($urandom);
            if (bus_if.reg_req && !was) begin
                if (cnt < 0) cnt = ack_delay - 1;
                if (cnt == 0) begin
                    bus_if.reg_ack   = 1'b1;
                    bus_if.reg_rdata = rdata_val;
                    cnt = -1;
                end else begin
                    cnt--;
                end
            end else if (!bus_if.reg_req) begin
                cnt = -1;
                if (noise_en && $urandom_range(0, 5) == 0) bus_if.reg_ack = 1'b1;
            end
        end
    end

    // Frame-level model: byte count in frame, op, whether this frame's request completed,
    // and how many bytes followed the completion.
    int          m_n;
    logic [7:0]  m_op;
    bit          m_stale, m_owned, m_done;
    int          m_k;
    logic        m_req, m_we;
    logic [7:0]  m_addr;
    logic [15:0] m_wdata, m_rdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n = 0; m_op = 8'h00; m_stale = 0; m_owned = 0; m_done = 0; m_k = 0;
            m_req = 0; m_we = 0; m_addr = 8'h00; m_wdata = 16'h0000; m_rdata = 16'h0000;
        end else begin
            logic req_pre;
            req_pre = m_req;
            if (cs_n) begin
                m_n = 0; m_owned = 0; m_done = 0; m_k = 0; m_stale = 0;
            end else if (rx_valid) begin
                if (m_n == 0) begin
                    m_op    = rx_data;
                    m_stale = req_pre;
                end else if (!m_stale && (m_op == 8'h01 || m_op == 8'h02)) begin
                    if (m_n == 1) begin
                        m_addr = rx_data;
                        if (m_op == 8'h01) begin m_req = 1; m_we = 0; m_owned = 1; end
                    end else if (m_op == 8'h02 && m_n == 2) begin
                        m_wdata[15:8] = rx_data;
                    end else if (m_op == 8'h02 && m_n == 3) begin
                        m_wdata[7:0] = rx_data;
                        m_req = 1; m_we = 1; m_owned = 1;
                    end else if (m_done) begin
                        m_k++;
                    end
                end
                m_n++;
            end
            if (req_pre && bus_if.reg_ack) begin
                m_req = 0;
                if (m_owned) begin
                    m_done  = 1;
                    m_k     = 0;
                    m_rdata = bus_if.reg_rdata;
                end
                m_owned = 0;
            end
        end
    end

    function automatic logic [7:0] exp_tx();
        if (m_n == 0 || m_stale) return 8'h00;
        case (m_op)
            8'h00: return 8'h01;
            8'h01: begin
                if (!m_done) return 8'h00;
                case (m_k)
                    0: return 8'h02;
                    1: return m_rdata[15:8];
                    2: return m_rdata[7:0];
                    default: return 8'h00;
                endcase
            end
            8'h02: begin
                if (!m_done) return 8'h00;
`ifdef RTMC_SPI_WR_ECHO_EN
                case (m_k)
                    0: return 8'h01;
                    1: return m_wdata[15:8];
                    2: return m_wdata[7:0];
                    default: return 8'h00;
                endcase
`else
                return 8'h01;
`endif
            end
            default: return 8'hFF;
        endcase
    endfunction

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_data", 32'(tx_data), 32'(exp_tx()));
            check("reg_req", 32'(bus_if.reg_req), 32'(m_req));
            check("reg_we", 32'(bus_if.reg_we), 32'(m_we));
            check("reg_addr", 32'(bus_if.reg_addr), 32'(m_addr));
            check("reg_wdata", 32'(bus_if.reg_wdata), 32'(m_wdata));
        end
    end

    int   req_rises = 0;
    logic req_prev = 1'b0;
    always @(negedge clk) begin
        if (bus_if.reg_req && !req_prev) req_rises++;
        req_prev = bus_if.reg_req;
    end

    task automatic send(input logic [7:0] b, input int gap, output logic [7:0] shifted);
        @(negedge clk);
        shifted  = tx_data;
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic start_frame();
        @(negedge clk);
        cs_n = 1'b0;
    endtask

    task automatic end_frame(input int gap);
        @(negedge clk);
        cs_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_req_low(input int limit);
        for (int i = 0; i < limit && bus_if.reg_req; i++) @(negedge clk);
        check("req_drop_timeout", 32'(bus_if.reg_req), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx"}, 32'(tx_data), 32'h00);
        check({tag, "_req"}, 32'(bus_if.reg_req), 32'd0);
        check({tag, "_we"}, 32'(bus_if.reg_we), 32'd0);
        check({tag, "_addr"}, 32'(bus_if.reg_addr), 32'h00);
        check({tag, "_wdata"}, 32'(bus_if.reg_wdata), 32'h0000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", checks, passed);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] s;
        logic [7:0] rd [4];
        int         rises0;
        logic [7:0] op;
        int         len;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst    = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Write 0x1234 to 0x03, ack three cycles after the request.
        ack_delay = 3;
        start_frame();
        send(8'h02, 1, s);
        send(8'h03, 1, s);
        send(8'h12, 1, s);
        send(8'h34, 0, s);
        check("wr_req", 32'(bus_if.reg_req), 32'd1);
        check("wr_we", 32'(bus_if.reg_we), 32'd1);
        check("wr_addr", 32'(bus_if.reg_addr), 32'h03);
        check("wr_wdata", 32'(bus_if.reg_wdata), 32'h1234);
        @(negedge clk);
        check("wr_req_held", 32'(bus_if.reg_req), 32'd1);
        repeat (2) @(negedge clk);
        check("wr_req_dropped", 32'(bus_if.reg_req), 32'd0);
        send(8'h00, 1, s);
        check("wr_poll", 32'(s), 32'h01);
        end_frame(2);

        // Read 0x06 with a zero-wait-state ack returning 0xBEEF.
        ack_delay = 1;
        rdata_val = 16'hBEEF;
        start_frame();
        send(8'h01, 1, s);
        send(8'h06, 2, s);
        for (int i = 0; i < 4; i++) send(8'h00, 1, rd[i]);
        check("rd_slot0", 32'(rd[0]), 32'h02);
        check("rd_slot1", 32'(rd[1]), 32'hBE);
        check("rd_slot2", 32'(rd[2]), 32'hEF);
        check("rd_slot3", 32'(rd[3]), 32'h00);
        end_frame(2);

        // Same read with the ack arriving well after the first poll.
        ack_delay = 10;
        rdata_val = 16'h5AA5;
        start_frame();
        send(8'h01, 1, s);
        send(8'h06, 1, s);
        send(8'h00, 1, s);
        check("rd_slow_poll0", 32'(s), 32'h00);
        wait_req_low(50);
        send(8'h00, 1, s);
        check("rd_slow_poll1", 32'(s), 32'h02);
        send(8'h00, 1, s);
        check("rd_slow_hi", 32'(s), 32'h5A);
        end_frame(2);

        // NOP and an unknown op.
        start_frame();
        send(8'h00, 1, s);
        for (int i = 0; i < 3; i++) begin
            send(8'($urandom), 1, s);
            check("nop_slot", 32'(s), 32'h01);
        end
        end_frame(2);
        rises0 = req_rises;
        start_frame();
        send(8'h7E, 1, s);
        for (int i = 0; i < 3; i++) begin
            send(8'h01, 1, s);
            check("bad_op_slot", 32'(s), 32'hFF);
        end
        end_frame(2);
        check("bad_op_no_req", 32'(req_rises - rises0), 32'd0);

        // Abort a read with its ack pending, then start a frame before the ack.
        ack_delay = 10;
        rises0 = req_rises;
        start_frame();
        send(8'h01, 1, s);
        send(8'h05, 0, s);
        end_frame(2);
        check("abort_tx", 32'(tx_data), 32'h00);
        check("abort_req_held", 32'(bus_if.reg_req), 32'd1);
        start_frame();
        send(8'h02, 1, s);
        for (int i = 0; i < 4; i++) begin
            send(8'hA0 + 8'(i), 1, s);
            check("stale_slot", 32'(s), 32'h00);
        end
        wait_req_low(50);
        end_frame(2);
        check("abort_one_req", 32'(req_rises - rises0), 32'd1);

        // Reset while a write is waiting for its ack.
        ack_delay = 20;
        start_frame();
        send(8'h02, 1, s);
        send(8'h11, 1, s);
        send(8'hAB, 1, s);
        send(8'hCD, 2, s);
        check("rst_pre_req", 32'(bus_if.reg_req), 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        #2 rst = 1'b0;
        cs_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write after reset; the poll sequence depends on write echo.
        ack_delay = 1;
        start_frame();
        send(8'h02, 1, s);
        send(8'h03, 1, s);
        send(8'hA5, 1, s);
        send(8'h5A, 2, s);
        for (int i = 0; i < 4; i++) send(8'h00, 1, rd[i]);
        check("echo_slot0", 32'(rd[0]), 32'h01);
`ifdef RTMC_SPI_WR_ECHO_EN
        check("echo_slot1", 32'(rd[1]), 32'hA5);
        check("echo_slot2", 32'(rd[2]), 32'h5A);
        check("echo_slot3", 32'(rd[3]), 32'h00);
`else
        check("echo_slot1", 32'(rd[1]), 32'h01);
        check("echo_slot2", 32'(rd[2]), 32'h01);
        check("echo_slot3", 32'(rd[3]), 32'h01);
`endif
        end_frame(2);

        // Randomized frames: mixed ops and lengths, aborts, spurious acks, stray bytes, rare resets.
        noise_en = 1'b1;
        for (int f = 0; f < 200; f++) begin
            ack_delay = $urandom_range(1, 6);
            rdata_val = 16'($urandom);
            case ($urandom_range(0, 5))
                0:       op = 8'h00;
                1, 2:    op = 8'h01;
                3, 4:    op = 8'h02;
                default: op = 8'($urandom);
            endcase
            len = $urandom_range(0, 8);
            start_frame();
            for (int i = 0; i < len; i++)
                send((i == 0) ? op : 8'($urandom), $urandom_range(0, 3), s);
            if ($urandom_range(0, 39) == 0) begin
                @(negedge clk);
                #2 rst = 1'b1;
                @(negedge clk);
                #2 rst = 1'b0;
            end
            end_frame($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                rx_valid = 1'b1;
                rx_data  = 8'($urandom);
                @(negedge clk);
                rx_valid = 1'b0;
            end
        end
        noise_en = 1'b0;
        wait_req_low(50);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/rtmc_spi_cmd.md
# rtmc_spi_cmd

SPI command engine for the motor controller. It sits between the SPI byte shifter (upstream) and the register bus (downstream). It parses the byte stream of each chip-select frame into register read/write requests, and it supplies the byte the shifter returns to the host on each slot. It implements the frame protocol using `op_t` (O_NOP/O_RD/O_WR) and `result_t` (R_BUSY/R_ACK/R_ACK_DATA) from `rtmc_pkg`.

## Interface
Parameters:
- `ADDR_W`, default `rtmc_pkg::ADDR_W` (8): register address width.
- `DATA_W`, default `rtmc_pkg::DATA_W` (16): register data width. Fixed at two bytes, high byte first.

Ports:
- `clk`: input, 1 bit. The single clock.
- `rst`: input, 1 bit. Reset, asynchronous and active-high.
- `cs_n`: input, 1 bit. Frame enable from the shifter, already synchronised; low means frame active.
- `rx_valid`: input, 1 bit. One-cycle pulse when a full byte has been received.
- `rx_data`: input, 8 bits. Received byte; valid when `rx_valid` is high.
- `tx_data`: output, 8 bits. Byte shifted out during the next byte slot.
- `reg_req`: output, 1 bit. Bus request; held high until `reg_ack`.
- `reg_we`: output, 1 bit. 1 = write, 0 = read; valid while `reg_req` is high.
- `reg_addr`: output, `ADDR_W` bits. Register address.
- `reg_wdata`: output, `DATA_W` bits. Write data.
- `reg_rdata`: input, `DATA_W` bits. Read data; valid in the `reg_ack` cycle.
- `reg_ack`: input, 1 bit. One-cycle completion pulse; may arrive 1 or more cycles after `reg_req` rises.

## Operation
- Frame = bytes received while `cs_n` is low. Byte 0 is the op code.
- Frame FSM states: IDLE, ADDR, WDH, WDL, WAIT, RDATH, RDATL, DONE, IGNORE.
- IDLE, on `rx_valid` (byte 0):
  - O_WR → ADDR.
  - O_RD → ADDR.
  - O_NOP → DONE; `tx_data` = R_ACK.
  - Any other value → IGNORE; `tx_data` = 0xFF.
- ADDR: capture `reg_addr`.
  - Write → WDH.
  - Read → WAIT; raise `reg_req` with `reg_we`=0.
- WDH: capture `reg_wdata[15:8]` → WDL.
- WDL: capture `reg_wdata[7:0]`; raise `reg_req` with `reg_we`=1 → WAIT.
- `tx_data` during ADDR/WDH/WDL is 0x00 (R_BUSY).
- WAIT:
  - `tx_data` = R_BUSY while `reg_req` is high.
  - On `reg_ack`: drop `reg_req`.
  - Read: latch `reg_rdata`, set `tx_data` = R_ACK_DATA.
  - Write: set `tx_data` = R_ACK.
  - Bytes received in WAIT are poll bytes and their content is ignored.
  - The first `rx_valid` after the ack: read → RDATH, write → DONE.
- Read data out:
  - In RDATH, `tx_data` = rdata[15:8]; the next `rx_valid` → RDATL.
  - In RDATL, `tx_data` = rdata[7:0]; the next `rx_valid` → DONE.
- DONE: `tx_data` holds the final result code (R_ACK for O_NOP/write, 0x00 after read data). Extra bytes are ignored.
- IGNORE: `tx_data` = 0xFF until the frame ends.
- `cs_n` rising in any state: frame FSM → IDLE, `tx_data` → 0x00.
- An outstanding `reg_req` is never abandoned. It stays high until `reg_ack`; the ack is consumed and read data is discarded.
- A new frame starting while `reg_req` is still pending from an aborted frame: the op byte is ignored, state → IGNORE, and `tx_data` = R_BUSY (0x00) instead of 0xFF.
- `rx_valid` while `cs_n` is high: ignored.

## Timing
- Reset values:
  - `tx_data` = 0x00, `reg_req` = 0, `reg_we` = 0.
  - `reg_addr` = 0, `reg_wdata` = 0, internal read latch = 0.
  - FSM = IDLE.
- `tx_data` updates on the clock edge that samples `rx_valid` (or `reg_ack` in WAIT). It then stays stable until the next such event, giving the shifter at least one full byte time of setup.
- `reg_req` rises on the edge that samples the final request byte (the address byte for a read, the data-low byte for a write).
- `reg_req` falls on the edge that samples `reg_ack`. `reg_addr`, `reg_we` and `reg_wdata` are stable while `reg_req` is high.
- `reg_ack` with `reg_req` low: ignored.
- Ack latency: a zero-wait-state bus (ack in the cycle after req rises) makes the first poll byte return the result.
- Reset during any state: immediate return to reset values; a pending bus request is dropped.

## Configuration
- `RTMC_SPI_WR_ECHO_EN` defined:
  - After a write's R_ACK is shifted, the next two slots return `reg_wdata[15:8]` then `reg_wdata[7:0]`, then 0x00.
  - The write path reuses RDATH/RDATL with the write data.
- Undefined: a write goes WAIT → DONE and keeps returning R_ACK.

## Test plan
- Write frame 02,03,12,34,00: `reg_req` rises with `reg_we`=1, addr 0x03, wdata 0x1234. Ack after 3 cycles. Poll byte returns 0x01; `reg_req` held until ack.
- Read frame 01,06,00,00,00,00 with ack returning 0xBEEF: shifted bytes after the addr byte are 0x02,0xBE,0xEF,0x00. Repeat with ack delayed past the first poll: the first poll returns 0x00.
- Op 0x00 → R_ACK on the following slots. Op 0x7E → 0xFF on all following slots; no `reg_req`.
- Abort: raise `cs_n` after a read address with ack pending 10 cycles. `reg_req` holds until ack. A new frame started before the ack returns 0x00 slots and issues no second request.
- Assert `rst` mid-WAIT → all outputs at reset values in the same cycle; the next write frame works normally.
- With `RTMC_SPI_WR_ECHO_EN`: write 0xA55A, poll → 0x01,0xA5,0x5A,0x00. Without the macro → 0x01,0x01,0x01.
